// File: rtl/sweeper_pkg.sv
// Shared types and sizing helpers for the exhaustive vector sweeper.
package sweeper_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    localparam logic [15:0] SIG_POLY_DEFAULT = 16'h1021;

    function automatic int unsigned vec_count(int unsigned n_inputs);
        return 32'd1 << n_inputs;
    endfunction

    // One extra bit so a full sweep of all-ones responses does not wrap.
    function automatic int unsigned count_width(int unsigned n_inputs);
        return n_inputs + 1;
    endfunction

endpackage

// File: rtl/sig_misr.sv
// 16-bit serial signature register: shift left, fold in POLY on MSB carry-out, XOR in bit_in.
module sig_misr
    import sweeper_pkg::*;
#(
    parameter logic [15:0] POLY = SIG_POLY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] sig
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ {15'b0, bit_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/vector_sweeper.sv
// Drives every input combination in binary order, holds each for a settle time,
// then samples a single-bit response into a ones-count and a serial signature.
module vector_sweeper
    import sweeper_pkg::*;
#(
    parameter int unsigned N_INPUTS      = 6,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] SIG_POLY      = SIG_POLY_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             w_in,
    output logic [N_INPUTS-1:0]              vec,
    output logic                             busy,
    output logic                             done,
    output logic [count_width(N_INPUTS)-1:0] ones_count,
    output logic [15:0]                      signature
);

    localparam int unsigned ONES_W = count_width(N_INPUTS);
    localparam int unsigned CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [N_INPUTS-1:0] vec_q, vec_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                misr_clr;
    logic                misr_en;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        busy_d   = busy_q;
        done_d   = done_q;
        ones_d   = ones_q;
        cnt_d    = cnt_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StSettle;
                    vec_d    = '0;
                    ones_d   = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    misr_clr = 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = StSample;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSample: begin
                misr_en = 1'b1;
                ones_d  = ones_q + ONES_W'(w_in);
                // Last vector stays on the bus after completion.
                if (&vec_q) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    vec_d   = vec_q + N_INPUTS'(1);
                    state_d = StSettle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ones_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
        end
    end

    sig_misr #(
        .POLY(SIG_POLY)
    ) u_sig_misr (
        .clk   (clk),
        .rst   (rst),
        .clr   (misr_clr),
        .en    (misr_en),
        .bit_in(w_in),
        .sig   (signature)
    );

    assign vec        = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_vector_sweeper.sv
// Directed bench for vector_sweeper: default 6-input sweep plus a 3-input, 1-cycle-settle instance.
module tb_vector_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        w_in;
    logic [5:0]  vec;
    logic        busy;
    logic        done;
    logic [6:0]  ones_count;
    logic [15:0] signature;
    int          mode;

    logic        start_s;
    logic        w_in_s;
    logic [2:0]  vec_s;
    logic        busy_s;
    logic        done_s;
    logic [3:0]  ones_s;
    logic [15:0] sig_s;

    int vectors;
    int miscompares;

    vector_sweeper dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .w_in      (w_in),
        .vec       (vec),
        .busy      (busy),
        .done      (done),
        .ones_count(ones_count),
        .signature (signature)
    );

    vector_sweeper #(
        .N_INPUTS     (3),
        .SETTLE_CYCLES(1)
    ) dut_s (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .w_in      (w_in_s),
        .vec       (vec_s),
        .busy      (busy_s),
        .done      (done_s),
        .ones_count(ones_s),
        .signature (sig_s)
    );

    function automatic logic ref_f(input logic [5:0] v);
        return (v[5] & v[4]) | (~v[3] & v[2]) | (v[1] ^ v[0]);
    endfunction

    always_comb begin
        w_in = 1'b0;
        case (mode)
            0: w_in = ref_f(vec);
            1: w_in = 1'b0;
            default: w_in = 1'b1;
        endcase
    end

    assign w_in_s = vec_s[0];

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ 16'h1021;
        n[0] = n[0] ^ b;
        return n;
    endfunction

    function automatic logic [15:0] sw_sig(input int m);
        logic [15:0] s;
        logic [5:0]  vv;
        logic        b;
        s = 16'h0000;
        for (int v = 0; v < 64; v++) begin
            vv = 6'(v);
            b  = (m == 0) ? ref_f(vv) : ((m == 1) ? 1'b0 : 1'b1);
            s  = misr_step(s, b);
        end
        return s;
    endfunction

    function automatic logic [15:0] sw_sig_small();
        logic [15:0] s;
        logic [2:0]  vv;
        s = 16'h0000;
        for (int v = 0; v < 8; v++) begin
            vv = 3'(v);
            s  = misr_step(s, vv[0]);
        end
        return s;
    endfunction

    // Pulses start, then counts edges until done; tracks vec/busy against the expected schedule.
    task automatic do_sweep(input int poke_at, output int cyc, output int errs);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc  = 0;
        errs = 0;
        if (vec !== 6'd0 || busy !== 1'b1 || done !== 1'b0) errs++;
        while (cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == poke_at);
            if (done === 1'b1) break;
            if (vec !== 6'(cyc / 3) || busy !== 1'b1) errs++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (vec !== 6'd0) begin
            miscompares++; $display("FAIL reset_vec got %0d want 0", vec);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done);
        end
        vectors++;
        if (ones_count !== 7'd0 || signature !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_results got ones=%0d sig=%h want 0 0000", ones_count, signature);
        end
        vectors++;
        if (busy_s !== 1'b0 || vec_s !== 3'd0) begin
            miscompares++; $display("FAIL reset_small got busy=%b vec=%0d want 0 0", busy_s, vec_s);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_function();
        int cyc, errs;
        mode = 0;
        do_sweep(-1, cyc, errs);
        vectors++;
        if (cyc !== 192) begin
            miscompares++; $display("FAIL func_latency got %0d want 192", cyc);
        end
        vectors++;
        if (errs !== 0) begin
            miscompares++; $display("FAIL func_vec_sequence got %0d errors want 0", errs);
        end
        vectors++;
        if (ones_count !== 7'd46) begin
            miscompares++; $display("FAIL func_ones got %0d want 46", ones_count);
        end
        vectors++;
        if (signature !== sw_sig(0)) begin
            miscompares++; $display("FAIL func_sig got %h want %h", signature, sw_sig(0));
        end
        vectors++;
        if (vec !== 6'd63 || busy !== 1'b0) begin
            miscompares++; $display("FAIL func_end got vec=%0d busy=%b want 63 0", vec, busy);
        end
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || ones_count !== 7'd46 || signature !== sw_sig(0) || vec !== 6'd63) begin
            miscompares++;
            $display("FAIL func_hold got done=%b ones=%0d sig=%h vec=%0d want 1 46 %h 63",
                     done, ones_count, signature, vec, sw_sig(0));
        end
    endtask

    task automatic test_tied();
        int cyc, errs;
        mode = 1;
        do_sweep(-1, cyc, errs);
        vectors++;
        if (ones_count !== 7'd0 || signature !== 16'h0000 || cyc !== 192) begin
            miscompares++;
            $display("FAIL tied0 got ones=%0d sig=%h cyc=%0d want 0 0000 192",
                     ones_count, signature, cyc);
        end
        mode = 2;
        do_sweep(-1, cyc, errs);
        vectors++;
        if (ones_count !== 7'd64) begin
            miscompares++; $display("FAIL tied1_ones got %0d want 64", ones_count);
        end
        vectors++;
        if (signature !== sw_sig(2)) begin
            miscompares++; $display("FAIL tied1_sig got %h want %h", signature, sw_sig(2));
        end
    endtask

    task automatic test_restart_ignored();
        int cyc, errs;
        mode = 0;
        do_sweep(50, cyc, errs);
        vectors++;
        if (cyc !== 192 || errs !== 0) begin
            miscompares++; $display("FAIL restart_timing got cyc=%0d errs=%0d want 192 0", cyc, errs);
        end
        vectors++;
        if (ones_count !== 7'd46 || signature !== sw_sig(0)) begin
            miscompares++;
            $display("FAIL restart_results got ones=%0d sig=%h want 46 %h",
                     ones_count, signature, sw_sig(0));
        end
    endtask

    task automatic test_reset_mid();
        int cyc, errs;
        mode = 2;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (vec !== 6'd0 || busy !== 1'b0 || done !== 1'b0 || ones_count !== 7'd0 ||
            signature !== 16'h0000) begin
            miscompares++;
            $display("FAIL midreset got vec=%0d busy=%b done=%b ones=%0d sig=%h want all 0",
                     vec, busy, done, ones_count, signature);
        end
        @(negedge clk) rst = 1'b0;
        mode = 0;
        do_sweep(-1, cyc, errs);
        vectors++;
        if (cyc !== 192 || errs !== 0 || ones_count !== 7'd46 || signature !== sw_sig(0)) begin
            miscompares++;
            $display("FAIL midreset_resweep got cyc=%0d errs=%0d ones=%0d sig=%h want 192 0 46 %h",
                     cyc, errs, ones_count, signature, sw_sig(0));
        end
    endtask

    task automatic test_small();
        int cyc;
        @(negedge clk) start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_s === 1'b1) break;
        end
        vectors++;
        if (cyc !== 16) begin
            miscompares++; $display("FAIL small_latency got %0d want 16", cyc);
        end
        vectors++;
        if (ones_s !== 4'd4 || vec_s !== 3'd7) begin
            miscompares++; $display("FAIL small_result got ones=%0d vec=%0d want 4 7", ones_s, vec_s);
        end
        vectors++;
        if (sig_s !== sw_sig_small()) begin
            miscompares++; $display("FAIL small_sig got %h want %h", sig_s, sw_sig_small());
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        start_s     = 1'b0;
        mode        = 0;
        test_reset();
        test_function();
        test_tied();
        test_restart_ignored();
        test_reset_mid();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
